// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous block RAM between the CPU
// and a secondary requester (DMA / video fetch). The CPU wins ties until it
// has taken MAX_CPU_STREAK consecutive grants while DMA waits; then DMA gets
// one slot. Read data returns one clock after the ack with a per-requester
// valid strobe.
module ram_arbiter #(
    parameter int ADDR_WIDTH     = 15,
    parameter int DATA_WIDTH     = 8,
    parameter int MAX_CPU_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,

    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_ack,
    output logic                  dma_rvalid,
    output logic [DATA_WIDTH-1:0] dma_rdata,

    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    // Who owns the read data arriving from the RAM in the next cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_CPU_STREAK);

    logic [3:0] streak_q, streak_d;
    owner_t     rd_owner_q, rd_owner_d;
    logic       grant_cpu, grant_dma;

    // Grant: one winner per cycle; nothing is granted while reset is held.
    always_comb begin
        grant_cpu = 1'b0;
        grant_dma = 1'b0;
        if (rst_n) begin
            if (cpu_req && dma_req) begin
                if (streak_q == STREAK_MAX) begin
                    grant_dma = 1'b1;
                end else begin
                    grant_cpu = 1'b1;
                end
            end else if (cpu_req) begin
                grant_cpu = 1'b1;
            end else if (dma_req) begin
                grant_dma = 1'b1;
            end
        end
    end

    // RAM port mux: the winner drives the port, idle cycles drive zeros.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (grant_cpu) begin
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end else if (grant_dma) begin
            ram_we    = dma_we;
            ram_addr  = dma_addr;
            ram_wdata = dma_wdata;
        end
    end

    // Next-state for the CPU streak counter and the read-return owner.
    always_comb begin
        streak_d   = '0;
        rd_owner_d = OWN_NONE;
        // Only CPU wins that make DMA wait count toward the streak.
        if (grant_cpu && dma_req) begin
            streak_d = (streak_q >= STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
        end
        if (grant_cpu && !cpu_we) begin
            rd_owner_d = OWN_CPU;
        end else if (grant_dma && !dma_we) begin
            rd_owner_d = OWN_DMA;
        end
    end

    // State registers; reset drops any read issued in the previous cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            streak_q   <= '0;
            rd_owner_q <= OWN_NONE;
        end else begin
            streak_q   <= streak_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign cpu_ack    = grant_cpu;
    assign dma_ack    = grant_dma;
    assign cpu_rvalid = (rd_owner_q == OWN_CPU);
    assign dma_rvalid = (rd_owner_q == OWN_DMA);
    assign cpu_rdata  = ram_rdata;
    assign dma_rdata  = ram_rdata;

endmodule
